// File: rtl/demux_1x2_bit32_fifo.sv
// 1-to-2 valid/ready demultiplexer. Each output port has its own small FIFO,
// so a stalled consumer on one port never blocks words routed to the other.

module demux_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic [AW:0]                 occ;
  logic                        do_pop;

  assign full   = (occ == (AW+1)'(DEPTH));
  assign valid  = (occ != '0);
  assign rdata  = mem[rptr];
  assign do_pop = pop & valid;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
        cnt       <= cnt + 1'b1;
      end
      if (do_pop)
        rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module demux_1x2_bit32_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic [1:0]             full, valid, push, pop;
  logic [1:0][WIDTH-1:0]  rdata;
  logic [1:0][CNT_W-1:0]  cnt;

  // Ready looks only at the selected FIFO's registered fullness, never at the
  // consumer's ready, so a full FIFO refuses a word even while being popped.
  assign in_ready = !full[in_sel];
  assign pop      = {out1_ready, out0_ready};

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign push[p] = in_valid & in_ready & (in_sel == 1'(p));
    demux_port_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[p]),
      .wdata (in_data),
      .pop   (pop[p]),
      .full  (full[p]),
      .valid (valid[p]),
      .rdata (rdata[p]),
      .cnt   (cnt[p])
    );
  end

  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out0_data  = rdata[0];
  assign out1_data  = rdata[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];
endmodule

// File: tb/tb_demux_1x2_bit32_fifo.sv
// Directed plus random stimulus against a queue-based reference model; a second
// instance with 4-bit counters exercises counter wrap on the same stimulus.

module tb_demux_1x2_bit32_fifo;
  localparam int W = 32;
  localparam int D = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid, in_sel, out0_ready, out1_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out0_valid, out1_valid;
  logic [W-1:0]  out0_data, out1_data;
  logic [15:0]   cnt0, cnt1;
  logic          w_in_ready, w_out0_valid, w_out1_valid;
  logic [W-1:0]  w_out0_data, w_out1_data;
  logic [3:0]    w_cnt0, w_cnt1;

  demux_1x2_bit32_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  demux_1x2_bit32_fifo #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out0_valid(w_out0_valid), .out0_ready(out0_ready), .out0_data(w_out0_data),
    .out1_valid(w_out1_valid), .out1_ready(out1_ready), .out1_data(w_out1_data),
    .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q0[$], q1[$];
  int  c0m, c1m;
  int  checks, errors;
  bit  dut_acc;
  int  n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    int sz;
    sz = in_sel ? q1.size() : q0.size();
    chk("in_ready", 64'(in_ready), 64'(sz < D));
    chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
    chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_data", 64'(out0_data), 64'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 64'(out1_data), 64'(q1[0]));
    chk("cnt0", 64'(cnt0), 64'(c0m[15:0]));
    chk("cnt1", 64'(cnt1), 64'(c1m[15:0]));
    chk("w_cnt0", 64'(w_cnt0), 64'(c0m[3:0]));
    chk("w_cnt1", 64'(w_cnt1), 64'(c1m[3:0]));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input bit v, input bit s, input logic [W-1:0] d,
                       input bit r0, input bit r1);
    bit acc, p0, p1;
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    check_outs();
    dut_acc = in_valid & in_ready;
    acc = v && ((s ? q1.size() : q0.size()) < D);
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (s) begin q1.push_back(d); c1m++; end
      else   begin q0.push_back(d); c0m++; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out0_valid", 64'(out0_valid), 64'(0));
    chk("rst_out1_valid", 64'(out1_valid), 64'(0));
    chk("rst_out0_data", 64'(out0_data), 64'(0));
    chk("rst_out1_data", 64'(out1_data), 64'(0));
    chk("rst_cnt0", 64'(cnt0), 64'(0));
    chk("rst_cnt1", 64'(cnt1), 64'(0));
    q0.delete(); q1.delete(); c0m = 0; c1m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_sel = 1'b0; #1 chk("rel_ready_sel0", 64'(in_ready), 64'(1));
    in_sel = 1'b1; #1 chk("rel_ready_sel1", 64'(in_ready), 64'(1));
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; c0m = 0; c1m = 0;
    in_valid = 0; in_sel = 0; in_data = '0; out0_ready = 0; out1_ready = 0;
    @(negedge clk);
    do_reset();

    // Single route
    cycle(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    in_valid = 1'b0; #1;
    chk("single_v0", 64'(out0_valid), 64'(1));
    chk("single_d0", 64'(out0_data), 64'h1234_5678);
    chk("single_v1", 64'(out1_valid), 64'(0));
    chk("single_cnt0", 64'(cnt0), 64'(1));
    chk("single_cnt1", 64'(cnt1), 64'(0));
    drain();

    // Backpressure isolation
    cycle(1'b1, 1'b1, 32'hA0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'hA1, 1'b1, 1'b0);
    in_sel = 1'b1; #1 chk("bp_ready_sel1", 64'(in_ready), 64'(0));
    cycle(1'b1, 1'b1, 32'hA2, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'hB0, 1'b1, 1'b0);
    chk("bp_b0_acc", 64'(dut_acc), 64'(1));
    in_valid = 1'b0; #1 chk("bp_out0_data", 64'(out0_data), 64'hB0);
    drain();

    // Streaming
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b0, 32'(k), 1'b1, 1'b0);
      if (dut_acc) n++;
    end
    chk("stream_accepts", 64'(n), 64'(8));
    drain();

    // Full plus pop
    cycle(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hC1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hC2, 1'b1, 1'b0);
    chk("full_pop_noacc", 64'(dut_acc), 64'(0));
    in_valid = 1'b1; in_sel = 1'b0; #1 chk("after_pop_ready", 64'(in_ready), 64'(1));
    drain();

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int k = 0; k < 17; k++) cycle(1'b1, 1'b1, 32'(k + 100), 1'b0, 1'b1);
    in_valid = 1'b0; #1;
    chk("wrap_w_cnt1", 64'(w_cnt1), 64'(1));
    chk("wrap_w_cnt0", 64'(w_cnt0), 64'(0));
    chk("wrap_cnt1", 64'(cnt1), 64'(17));

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle(($urandom % 4) != 0, 1'($urandom), $urandom,
            ($urandom % 3) != 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
